// File: rtl/cmp_pkg.sv
// Shared types and constants for the round-robin comparator arbiter.
// Sign codes feed the downstream seven-segment HEX decoders.
package cmp_pkg;

    localparam int unsigned DEF_W    = 4;
    localparam int unsigned DEF_NREQ = 4;

    localparam logic [3:0] SIGN_MINUS = 4'hA;
    localparam logic [3:0] SIGN_BLANK = 4'hB;

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StResp
    } state_e;

endpackage

// File: rtl/cmp_core.sv
// Combinational sign-aware magnitude comparator with sign/magnitude display fields.
// In unsigned mode both operands are treated as non-negative raw values.
module cmp_core #(
    parameter int unsigned W = 4
) (
    input  logic         sgn,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         gt,
    output logic         eq,
    output logic         neg_a,
    output logic         neg_b,
    output logic [W-1:0] abs_a,
    output logic [W-1:0] abs_b
);

    always_comb begin
        eq    = (a == b);
        neg_a = sgn & a[W-1];
        neg_b = sgn & b[W-1];
        // Differing MSBs in signed mode: the operand with MSB set is the smaller one.
        if (sgn && (a[W-1] != b[W-1])) begin
            lt = a[W-1];
        end else begin
            lt = (a < b);
        end
        gt    = ~lt & ~eq;
        abs_a = neg_a ? (~a + W'(1)) : a;
        abs_b = neg_b ? (~b + W'(1)) : b;
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one cmp_core among NREQ requesters over a
// four-phase REQ/ACK handshake; results stay valid while ACK is held.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter  int unsigned NREQ = DEF_NREQ,
    parameter  int unsigned W    = DEF_W,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*W-1:0] A_IN,
    input  logic [NREQ*W-1:0] B_IN,
    input  logic [NREQ-1:0]   SIGNED_IN,
    output logic [NREQ-1:0]   ACK,
    output logic [IDW-1:0]    RES_ID,
    output logic              RES_LT,
    output logic              RES_GT,
    output logic              RES_EQ,
    output logic              RES_NEG_A,
    output logic              RES_NEG_B,
    output logic [W-1:0]      RES_ABS_A,
    output logic [W-1:0]      RES_ABS_B,
    output logic              BUSY
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sgn_q, sgn_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
    logic            nega_q, nega_d, negb_q, negb_d;
    logic [W-1:0]    absa_q, absa_d, absb_q, absb_d;

    logic            grant_valid;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  ptr_next;

    logic            core_lt, core_gt, core_eq, core_nega, core_negb;
    logic [W-1:0]    core_absa, core_absb;

    cmp_core #(
        .W (W)
    ) u_core (
        .sgn   (sgn_q),
        .a     (a_q),
        .b     (b_q),
        .lt    (core_lt),
        .gt    (core_gt),
        .eq    (core_eq),
        .neg_a (core_nega),
        .neg_b (core_negb),
        .abs_a (core_absa),
        .abs_b (core_absb)
    );

    // Scan from the farthest offset down so the nearest requester at/after ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            int j;
            j = (int'(ptr_q) + i) % int'(NREQ);
            if (REQ[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(j);
            end
        end
    end

    assign ptr_next = (idx_q == IDW'(NREQ - 1)) ? '0 : idx_q + IDW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        ack_d   = ack_q;
        id_d    = id_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        nega_d  = nega_q;
        negb_d  = negb_q;
        absa_d  = absa_q;
        absb_d  = absb_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    idx_d   = grant_idx;
                    a_d     = A_IN[grant_idx*W +: W];
                    b_d     = B_IN[grant_idx*W +: W];
                    sgn_d   = SIGNED_IN[grant_idx];
                    state_d = StCmp;
                end
            end
            StCmp: begin
                if (REQ[idx_q]) begin
                    lt_d    = core_lt;
                    gt_d    = core_gt;
                    eq_d    = core_eq;
                    nega_d  = core_nega;
                    negb_d  = core_negb;
                    absa_d  = core_absa;
                    absb_d  = core_absb;
                    id_d    = idx_q;
                    ack_d   = NREQ'(1) << idx_q;
                    state_d = StResp;
                end else begin
                    // Withdrawn before the result: skip past it so others are not starved.
                    ptr_d   = ptr_next;
                    state_d = StIdle;
                end
            end
            StResp: begin
                if (!REQ[idx_q]) begin
                    ack_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            ack_q   <= '0;
            id_q    <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            nega_q  <= 1'b0;
            negb_q  <= 1'b0;
            absa_q  <= '0;
            absb_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            ack_q   <= ack_d;
            id_q    <= id_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            nega_q  <= nega_d;
            negb_q  <= negb_d;
            absa_q  <= absa_d;
            absb_q  <= absb_d;
        end
    end

    assign ACK       = ack_q;
    assign RES_ID    = id_q;
    assign RES_LT    = lt_q;
    assign RES_GT    = gt_q;
    assign RES_EQ    = eq_q;
    assign RES_NEG_A = nega_q;
    assign RES_NEG_B = negb_q;
    assign RES_ABS_A = absa_q;
    assign RES_ABS_B = absb_q;
    assign BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter: reset, compare modes,
// round-robin order, withdrawal and reset during a handshake.
module tb_cmp_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 4;
    localparam int unsigned IDW  = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NREQ-1:0]   REQ;
    logic [NREQ*W-1:0] A_IN;
    logic [NREQ*W-1:0] B_IN;
    logic [NREQ-1:0]   SIGNED_IN;
    logic [NREQ-1:0]   ACK;
    logic [IDW-1:0]    RES_ID;
    logic              RES_LT, RES_GT, RES_EQ, RES_NEG_A, RES_NEG_B;
    logic [W-1:0]      RES_ABS_A, RES_ABS_B;
    logic              BUSY;

    int tests = 0;
    int fails = 0;

    cmp_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .A_IN      (A_IN),
        .B_IN      (B_IN),
        .SIGNED_IN (SIGNED_IN),
        .ACK       (ACK),
        .RES_ID    (RES_ID),
        .RES_LT    (RES_LT),
        .RES_GT    (RES_GT),
        .RES_EQ    (RES_EQ),
        .RES_NEG_A (RES_NEG_A),
        .RES_NEG_B (RES_NEG_B),
        .RES_ABS_A (RES_ABS_A),
        .RES_ABS_B (RES_ABS_B),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic s);
        A_IN[i*4 +: 4] = a;
        B_IN[i*4 +: 4] = b;
        SIGNED_IN[i]   = s;
    endtask

    task automatic wait_ack();
        for (int c = 0; c < 12; c++) begin
            if (ACK !== '0) break;
            step();
        end
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        RST       = 1'b1;
        REQ       = 4'hF;
        A_IN      = '0;
        B_IN      = '0;
        SIGNED_IN = '0;
        set_op(0, 4'd9, 4'd3, 1'b0);
        step();
        step();
        chk("rst_ack", ACK, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_id", RES_ID, 0);
        chk("rst_ltgteq", {RES_LT, RES_GT, RES_EQ}, 0);
        chk("rst_abs", {RES_ABS_A, RES_ABS_B}, 0);
        chk("rst_neg", {RES_NEG_A, RES_NEG_B}, 0);

        // First grant after reset goes to requester 0; unsigned 9 vs 3.
        RST = 1'b0;
        step();
        chk("u_cmp_ack", ACK, 0);
        chk("u_cmp_busy", BUSY, 1);
        step();
        chk("u_ack", ACK, 4'b0001);
        chk("u_id", RES_ID, 0);
        chk("u_flags", {RES_LT, RES_GT, RES_EQ}, 3'b010);
        chk("u_abs_a", RES_ABS_A, 9);
        chk("u_abs_b", RES_ABS_B, 3);
        chk("u_neg", {RES_NEG_A, RES_NEG_B}, 0);
        REQ = 4'h0;
        step();
        chk("u_release_ack", ACK, 0);
        chk("u_release_busy", BUSY, 0);

        // Signed 9 (-7) vs 3.
        set_op(1, 4'd9, 4'd3, 1'b1);
        REQ = 4'b0010;
        step();
        step();
        chk("s_ack", ACK, 4'b0010);
        chk("s_id", RES_ID, 1);
        chk("s_flags", {RES_LT, RES_GT, RES_EQ}, 3'b100);
        chk("s_neg", {RES_NEG_A, RES_NEG_B}, 2'b10);
        chk("s_abs_a", RES_ABS_A, 7);
        chk("s_abs_b", RES_ABS_B, 3);
        // Operand change and another request while busy must not disturb results.
        set_op(1, 4'd0, 4'd0, 1'b0);
        REQ = 4'b0011;
        step();
        chk("s_hold_ack", ACK, 4'b0010);
        chk("s_hold_abs", RES_ABS_A, 7);
        chk("s_hold_lt", RES_LT, 1);
        REQ = 4'h0;
        step();

        // Signed most-negative vs itself.
        set_op(1, 4'h8, 4'h8, 1'b1);
        REQ = 4'b0010;
        step();
        step();
        chk("mn_ack", ACK, 4'b0010);
        chk("mn_flags", {RES_LT, RES_GT, RES_EQ}, 3'b001);
        chk("mn_abs", {RES_ABS_A, RES_ABS_B}, 8'h88);
        chk("mn_neg", {RES_NEG_A, RES_NEG_B}, 2'b11);
        REQ = 4'h0;
        step();

        // Round robin from a fresh pointer.
        RST = 1'b1;
        step();
        RST = 1'b0;
        REQ = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ack();
            chk("rr_ack", ACK, 32'(1) << order[k]);
            chk("rr_id", RES_ID, order[k]);
            step();
            REQ[order[k]] = 1'b0;
            step();
            chk("rr_gap", ACK, 0);
            REQ[order[k]] = 1'b1;
        end
        REQ = 4'h0;
        step();

        // Withdrawal: requester 2 drops after one cycle, requester 3 then served.
        set_op(3, 4'hF, 4'h1, 1'b1);
        REQ = 4'b0100;
        step();
        REQ = 4'b1000;
        step();
        chk("wd_ack", ACK, 0);
        chk("wd_busy", BUSY, 0);
        chk("wd_id_kept", RES_ID, 0);
        step();
        chk("wd_cmp_ack", ACK, 0);
        step();
        chk("wd_next_ack", ACK, 4'b1000);
        chk("wd_next_id", RES_ID, 3);
        chk("wd_next_flags", {RES_LT, RES_GT, RES_EQ}, 3'b100);
        chk("wd_next_abs", RES_ABS_A, 1);
        chk("wd_next_neg", {RES_NEG_A, RES_NEG_B}, 2'b10);
        REQ = 4'h0;
        step();

        // Serve 2 so the pointer moves to 3, then reset mid-handshake with requester 1.
        REQ = 4'b0100;
        step();
        step();
        chk("mr_pre_ack", ACK, 4'b0100);
        REQ = 4'h0;
        step();
        REQ = 4'b0010;
        step();
        step();
        chk("mr_resp_ack", ACK, 4'b0010);
        RST = 1'b1;
        step();
        chk("mr_rst_ack", ACK, 0);
        chk("mr_rst_busy", BUSY, 0);
        chk("mr_rst_id", RES_ID, 0);
        RST = 1'b0;
        REQ = 4'b1110;
        step();
        step();
        chk("mr_after_ack", ACK, 4'b0010);
        chk("mr_after_id", RES_ID, 1);
        REQ = 4'h0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
